// File: rtl/sprite_rom_arbiter_if.sv
// Request/grant, image-ROM port and tagged read-return signals of sprite_rom_arbiter.
// The master side belongs to the draw stages and the ROM; the slave side belongs to the arbiter.
interface sprite_rom_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12
);
    logic                      arb_en;
    logic [N_REQ-1:0]          req;
    logic [N_REQ*ADDR_W-1:0]   req_addr;
    logic [N_REQ-1:0]          gnt;
    logic                      rom_en;
    logic [ADDR_W-1:0]         rom_addr;
    logic [DATA_W-1:0]         rom_data;
    logic [N_REQ-1:0]          rd_valid;
    logic [DATA_W-1:0]         rd_data;

    modport master (
        output arb_en, req, req_addr, rom_data,
        input  gnt, rom_en, rom_addr, rd_valid, rd_data
    );

    modport slave (
        input  arb_en, req, req_addr, rom_data,
        output gnt, rom_en, rom_addr, rd_valid, rd_data
    );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous image-ROM read port between N_REQ draw stages (round-robin, one grant/cycle).
// Define SPRITE_ROM_ARB_FIXED_PRI_EN to use fixed lowest-index-wins priority instead of round-robin.
module sprite_rom_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12,
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    sprite_rom_arbiter_if.slave bus
);
    logic [N_REQ-1:0]            gnt;
    logic                        rom_en_q;
    logic [ADDR_W-1:0]           rom_addr_q;
    logic [ADDR_W-1:0]           rom_addr_d;
    logic [RD_LAT:0][N_REQ-1:0]  tag_q;
    logic [DATA_W-1:0]           rd_data;

    function automatic logic [ADDR_W-1:0] addr_mux(input logic [N_REQ*ADDR_W-1:0] addrs,
                                                   input logic [N_REQ-1:0]        oh);
        logic [ADDR_W-1:0] a;
        a = '0;
        for (int k = 0; k < N_REQ; k++)
            if (oh[k]) a = addrs[k*ADDR_W +: ADDR_W];
        return a;
    endfunction

`ifdef SPRITE_ROM_ARB_FIXED_PRI_EN
    // Lowest set bit wins; isolating it keeps gnt one-hot without a priority chain.
    always_comb begin
        gnt = '0;
        if (!rst && bus.arb_en) gnt = bus.req & (~bus.req + 1'b1);
    end
`else
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SUM_W = PTR_W + 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Scan ptr, ptr+1, ... with an explicit wrap so non-power-of-two N_REQ never indexes past the end.
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [PTR_W-1:0] p);
        logic [N_REQ-1:0] g;
        logic [SUM_W-1:0] sum;
        logic [PTR_W-1:0] idx;
        logic             done;
        g    = '0;
        done = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, p} + SUM_W'(k);
            if (sum >= SUM_W'(N_REQ)) sum = sum - SUM_W'(N_REQ);
            idx = sum[PTR_W-1:0];
            if (!done && r[idx]) begin
                g[idx] = 1'b1;
                done   = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [PTR_W-1:0] oh2idx(input logic [N_REQ-1:0] oh);
        logic [PTR_W-1:0] i;
        i = '0;
        for (int k = 0; k < N_REQ; k++)
            if (oh[k]) i = PTR_W'(k);
        return i;
    endfunction

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        if (!rst && bus.arb_en) gnt = rr_pick(bus.req, ptr_q);
        if (|gnt) begin
            if (oh2idx(gnt) == PTR_W'(N_REQ - 1)) ptr_d = '0;
            else                                  ptr_d = oh2idx(gnt) + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`endif

    assign rom_addr_d = (|gnt) ? addr_mux(bus.req_addr, gnt) : rom_addr_q;

    // Issue stage registers the ROM request; tag_q[0] travels with rom_en, tag_q[RD_LAT] meets rom_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            tag_q      <= '0;
        end else begin
            rom_en_q   <= |gnt;
            rom_addr_q <= rom_addr_d;
            tag_q      <= {tag_q[RD_LAT-1:0], gnt};
        end
    end

    assign rd_data      = bus.rom_data;
    assign bus.gnt      = gnt;
    assign bus.rom_en   = rom_en_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.rd_valid = tag_q[RD_LAT];
    assign bus.rd_data  = rd_data;
endmodule
